// File: rtl/mult_div_ctrl_if.sv
// Request/response bundle between the main control FSM and the HI/LO
// multiply/divide sequencer.
interface mult_div_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              op;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              hi_write;
  logic              lo_write;
  logic              div0;

  modport master (
    output start, op, rs_data, rt_data, flush,
    input  busy, done, hi_out, lo_out,
    input  hi_write, lo_write, div0
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush,
    output busy, done, hi_out, lo_out,
    output hi_write, lo_write, div0
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative signed shift-add multiply / restoring divide feeding HI/LO.
// Define MULTDIV_DIV0_EXC_EN to trap zero divisors via div0 (no HI/LO write).
module mult_div_ctrl #(
  parameter int DATA_W = 32
) (
  input logic           clock,
  input logic           reset,
  mult_div_ctrl_if.slave md
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    FIX,
    DONE,
    DONE_EXC
  } state_t;

  state_t state, nstate;

  logic                pend;
  logic                op_q;
  logic [DATA_W-1:0]   rs_q;
  logic [DATA_W-1:0]   rt_q;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   dvsr;
  logic                psign;
  logic                rsign;
  logic [2*DATA_W-1:0] acc;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic                rt_zero;
  logic [DATA_W:0]     msum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     dt;
  logic [DATA_W:0]     ddiff;
  logic                qbit;
  logic [DATA_W-1:0]   rem_n;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  function automatic logic [DATA_W-1:0] mag(
    input logic [DATA_W-1:0] v
  );
    return v[DATA_W-1] ? -v : v;
  endfunction

  assign rt_zero = (rt_q == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (pend) nstate = LOAD;
      LOAD: begin
        nstate = CALC;
`ifdef MULTDIV_DIV0_EXC_EN
        if (op_q && rt_zero) nstate = DONE_EXC;
`endif
      end
      CALC:     if (cnt == LAST) nstate = FIX;
      FIX:      nstate = DONE;
      DONE:     nstate = IDLE;
      DONE_EXC: nstate = IDLE;
      default:  nstate = IDLE;
    endcase
    if (md.flush && state != IDLE) nstate = IDLE;
  end

  // One shift-add step: acc = {partial high, remaining multiplier bits}
  always_comb begin
    msum = {1'b0, acc[2*DATA_W-1:DATA_W]}
         + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {msum, acc[DATA_W-1:1]};
  end

  // One restoring step: acc = {remainder, dividend/quotient bits}
  always_comb begin
    dt       = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    ddiff    = dt - {1'b0, dvsr};
    qbit     = ~ddiff[DATA_W];
    rem_n    = qbit ? ddiff[DATA_W-1:0] : dt[DATA_W-1:0];
    div_next = {rem_n, acc[DATA_W-2:0], qbit};
  end

  always_comb begin
    prod   = psign ? -acc : acc;
    fix_hi = prod[2*DATA_W-1:DATA_W];
    fix_lo = prod[DATA_W-1:0];
    if (op_q) begin
      fix_lo = psign ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
      fix_hi = rsign ? -acc[2*DATA_W-1:DATA_W]
                     : acc[2*DATA_W-1:DATA_W];
      if (rt_zero) begin
        fix_hi = rs_q;
        fix_lo = '1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0;
      op_q <= 1'b0;
      rs_q <= '0;
      rt_q <= '0;
    end else begin
      pend <= (state == IDLE) && !pend && md.start;
      if (state == IDLE && !pend && md.start) begin
        op_q <= md.op;
        rs_q <= md.rs_data;
        rt_q <= md.rt_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand <= '0;
      dvsr  <= '0;
      psign <= 1'b0;
      rsign <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          mcand <= mag(rs_q);
          dvsr  <= mag(rt_q);
          psign <= rs_q[DATA_W-1] ^ rt_q[DATA_W-1];
          rsign <= rs_q[DATA_W-1];
          acc   <= {{DATA_W{1'b0}},
                    op_q ? mag(rs_q) : mag(rt_q)};
          cnt   <= '0;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= op_q ? div_next : mul_next;
        end
        FIX: begin
          if (!md.flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign md.busy     = (state != IDLE);
  assign md.done     = (state == DONE) || (state == DONE_EXC);
  assign md.hi_write = (state == DONE);
  assign md.lo_write = (state == DONE);
  assign md.hi_out   = hi_q;
  assign md.lo_out   = lo_q;
`ifdef MULTDIV_DIV0_EXC_EN
  assign md.div0     = (state == DONE_EXC);
`else
  assign md.div0     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: latency, results, flush, reset.
module tb_mult_div_ctrl;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mult_div_ctrl_if #(.DATA_W(W)) md ();

  mult_div_ctrl #(.DATA_W(W)) dut (
    .clock (clock),
    .reset (reset),
    .md    (md)
  );

  int n_chk = 0;
  int n_fail = 0;

  int         r_lat;
  int         r_ndone;
  int         r_nwr;
  int         r_nbusy;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic       r_wr;
  logic       r_div0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input logic op,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input int xs,
                     input int fl);
    md.op      = op;
    md.rs_data = a;
    md.rt_data = b;
    md.start   = 1'b1;
    tick();
    md.start = 1'b0;
    r_lat = -1; r_ndone = 0; r_nwr = 0; r_nbusy = 0;
    r_hi = '0; r_lo = '0; r_wr = 1'b0; r_div0 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      md.start = (i == xs);
      md.flush = (i == fl);
      if (i == 1) begin
        md.rs_data = ~a;
        md.rt_data = ~b;
      end
      tick();
      if (md.busy) r_nbusy++;
      if (md.hi_write || md.lo_write) r_nwr++;
      if (md.div0) r_div0 = 1'b1;
      if (md.done) begin
        r_ndone++;
        if (r_lat < 0) begin
          r_lat = i;
          r_hi  = md.hi_out;
          r_lo  = md.lo_out;
          r_wr  = md.hi_write & md.lo_write;
        end
      end
    end
    md.start = 1'b0;
    md.flush = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(md.busy), 64'd0);
    check({tag, "_done"}, 64'(md.done), 64'd0);
    check({tag, "_hiw"}, 64'(md.hi_write), 64'd0);
    check({tag, "_low"}, 64'(md.lo_write), 64'd0);
    check({tag, "_div0"}, 64'(md.div0), 64'd0);
    check({tag, "_hi"}, 64'(md.hi_out), 64'd0);
    check({tag, "_lo"}, 64'(md.lo_out), 64'd0);
  endtask

  initial begin
    int nd;
    md.start = 1'b0;
    md.flush = 1'b0;
    md.op = 1'b0;
    md.rs_data = '0;
    md.rt_data = '0;
    tick();
    tick();
    check_zero("rst");
    reset = 1'b1;
    tick();

    run(1'b0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    check("m1_lat", 64'(r_lat), 64'd35);
    check("m1_hi", 64'(r_hi), 64'hFFFF_FFFF);
    check("m1_lo", 64'(r_lo), 64'hFFFF_FFEB);
    check("m1_wr", 64'(r_wr), 64'd1);
    check("m1_nwr", 64'(r_nwr), 64'd1);
    check("m1_ndone", 64'(r_ndone), 64'd1);

    run(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    check("m2_hi", 64'(r_hi), 64'h4000_0000);
    check("m2_lo", 64'(r_lo), 64'h0);
    check("m2_busy", 64'(r_nbusy), 64'd35);

    run(1'b1, 32'hFFFF_FFF9, 32'd2, 10, 0);
    check("d1_lo", 64'(r_lo), 64'hFFFF_FFFD);
    check("d1_hi", 64'(r_hi), 64'hFFFF_FFFF);
    check("d1_ndone", 64'(r_ndone), 64'd1);
    check("d1_lat", 64'(r_lat), 64'd35);

    run(1'b1, 32'h1234_5678, 32'd0, 0, 0);
`ifdef MULTDIV_DIV0_EXC_EN
    check("z_lat", 64'(r_lat), 64'd2);
    check("z_div0", 64'(r_div0), 64'd1);
    check("z_nwr", 64'(r_nwr), 64'd0);
    check("z_busy", 64'(r_nbusy), 64'd2);
    check("z_hi", 64'(md.hi_out), 64'hFFFF_FFFF);
    check("z_lo", 64'(md.lo_out), 64'hFFFF_FFFD);
`else
    check("z_lat", 64'(r_lat), 64'd35);
    check("z_div0", 64'(r_div0), 64'd0);
    check("z_hi", 64'(r_hi), 64'h1234_5678);
    check("z_lo", 64'(r_lo), 64'hFFFF_FFFF);
    check("z_nwr", 64'(r_nwr), 64'd1);
`endif
    check("z_ndone", 64'(r_ndone), 64'd1);

    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("ov_lo", 64'(r_lo), 64'h8000_0000);
    check("ov_hi", 64'(r_hi), 64'h0);

    run(1'b0, 32'd3, 32'd5, 0, 11);
    check("fl_ndone", 64'(r_ndone), 64'd0);
    check("fl_nwr", 64'(r_nwr), 64'd0);
    check("fl_busy", 64'(r_nbusy), 64'd10);
    check("fl_hi", 64'(md.hi_out), 64'h0);
    check("fl_lo", 64'(md.lo_out), 64'h8000_0000);

    run(1'b0, 32'd6, 32'd7, 0, 0);
    check("af_lat", 64'(r_lat), 64'd35);
    check("af_lo", 64'(r_lo), 64'd42);
    check("af_hi", 64'(r_hi), 64'd0);

    md.op = 1'b0;
    md.rs_data = 32'd5;
    md.rt_data = 32'd9;
    md.start = 1'b1;
    tick();
    md.start = 1'b0;
    repeat (20) tick();
    reset = 1'b0;
    #1;
    check_zero("mrst");
    tick();
    reset = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (md.done || md.hi_write || md.lo_write) nd++;
    end
    check("mrst_quiet", 64'(nd), 64'd0);

    run(1'b1, 32'd100, 32'd7, 0, 0);
    check("d2_lo", 64'(r_lo), 64'd14);
    check("d2_hi", 64'(r_hi), 64'd2);
    check("d2_lat", 64'(r_lat), 64'd35);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Sequencer and iterative engine for the signed multiply/divide resource that feeds the HI and LO registers.
The main control unit pulses start with an operation code and two operands (rs, rt). The block runs a fixed-latency shift-add multiply or restoring divide and holds busy while it runs. At the end it drives HI/LO write strobes and a one-cycle done, so the main FSM can stall on busy and resume on done.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = MULT (signed), 1 = DIV (signed)
rs_data  input  DATA_W  multiplicand / dividend
rt_data  input  DATA_W  multiplier / divisor
flush  input  1  abort current operation (exception path)
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
hi_out  output  DATA_W  MULT: product[63:32]; DIV: remainder
lo_out  output  DATA_W  MULT: product[31:0]; DIV: quotient
hi_write  output  1  HI register write enable
lo_write  output  1  LO register write enable
div0  output  1  divide-by-zero pulse (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0; busy, done, hi_write, lo_write, div0 = 0; hi_out = lo_out = 0; internal registers cleared.
- FSM states:
  - IDLE: on start=1 → LOAD. Capture op and the operands.
  - LOAD: store operand magnitudes (two's-complement negate if negative) and the result sign (MULT: sign(rs)^sign(rt); DIV quotient: sign(rs)^sign(rt); remainder: sign(rs)). Clear the accumulator and set counter=0. → CALC.
  - CALC: one iteration per cycle; counter increments. After DATA_W iterations (counter = DATA_W-1 on the last one) → FIX.
  - FIX: apply sign corrections and load hi_out/lo_out. → DONE.
  - DONE: done=hi_write=lo_write=1 for exactly this cycle. → IDLE.
- MULT: unsigned 2·DATA_W shift-add on the magnitudes, then negate the full 2·DATA_W product if the result sign is 1.
- DIV: unsigned restoring division on the magnitudes. Quotient and remainder are negated per the sign rules. Truncation is toward zero, so the remainder takes the sign of the dividend.
- Latency:
  - Start sampled at edge E. LOAD occupies cycle E+1, CALC E+2..E+33, FIX E+34, DONE E+35 (DATA_W=32).
  - Total: done rises DATA_W+3 edges after the start edge.
- busy is high from LOAD through DONE inclusive, and low in IDLE.
- hi_out/lo_out hold their last value until the next FIX, and are stable while done is high.
- start while busy (any non-IDLE state, DONE included) is ignored. There is no queueing.
- flush=1 in any non-IDLE state → IDLE on the next edge. No write strobes and no done; hi_out/lo_out unchanged. flush in IDLE has no effect.
- flush and start both high in IDLE: start wins.
- Overflow cases (e.g. MIN_INT / -1) produce the natural wrapped result with no flag: LO=0x80000000, HI=0.
- Reset asserted mid-operation aborts immediately. No strobes are emitted after reset is released.

Optional Feature:
MULTDIV_DIV0_EXC_EN
- Defined:
  - DIV with rt_data=0 goes IDLE→LOAD→DONE_EXC.
  - DONE_EXC asserts div0=1 and done=1 for one cycle with hi_write=lo_write=0. HI/LO are unchanged.
  - done therefore rises 2 edges after start.
- Not defined:
  - div0 is tied to 0 and a zero divisor runs the full sequence.
  - The forced result is hi_out=rs_data, lo_out=all ones, written normally at DATA_W+3.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) → done at edge E+35; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, hi_write=lo_write=1 for one cycle.
- MULT rs=rt=0x80000000 → hi_out=0x40000000, lo_out=0x00000000; busy high for exactly 35 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1); a second start pulsed mid-run is ignored and yields only one done.
- DIV rt=0:
  - With MULTDIV_DIV0_EXC_EN: div0=done=1 at E+2, no writes, hi_out/lo_out retain their prior values.
  - Without it: at E+35, hi_out=rs_data, lo_out=0xFFFFFFFF, div0=0.
- flush at E+10 during MULT → IDLE at E+11, busy=0, no done/strobes; a new start then completes normally.
- reset=0 at E+20 → all outputs 0 immediately. Release reset, start DIV 100/7 → lo_out=14, hi_out=2.
